// File: rtl/chronospatial_cpu_if.sv
// Output stream of the chronospatial CPU: 3-bit values from the output FIFO.
// The master presents out_data/out_valid. The slave pops the head with out_ready.
// out_ready while out_valid is low has no effect.
interface chronospatial_cpu_if;
   logic [2:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/chronospatial_cpu.sv
// 3-bit program CPU with A/B/C registers and an output FIFO (chronospatial machine).
// Each instruction takes 2 cycles (FETCH, EXEC). Programs of length 0/1 halt 1 cycle after start.
// When the FIFO is full, an out instruction waits in STALL until a slot is free at cycle start.
module chronospatial_cpu #(
   parameter int REG_W      = 48,
   parameter int PROG_DEPTH = 16,
   parameter int OUT_DEPTH  = 4,
   localparam int PW        = $clog2(PROG_DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_en,
   input  logic [PW-1:0]    load_addr,
   input  logic [2:0]       load_data,
   input  logic [PW:0]      prog_len,
   input  logic [REG_W-1:0] init_a,
   input  logic [REG_W-1:0] init_b,
   input  logic [REG_W-1:0] init_c,
   input  logic             start,
   output logic             busy,
   output logic             halt,
   output logic             error,
   output logic [REG_W-1:0] dbg_a,
   output logic [REG_W-1:0] dbg_b,
   output logic [REG_W-1:0] dbg_c,
   chronospatial_cpu_if.master out_if
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_STALL = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   // ip can reach prog_len+1 and must also hold any 3-bit jump literal.
   localparam int IPW = (PW + 2 < 3) ? 3 : PW + 2;
   localparam int FW  = $clog2(OUT_DEPTH);

   logic [2:0]       state_q, state_d;
   logic [REG_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
   logic [IPW-1:0]   ip_q, ip_d;
   logic [PW:0]      len_q, len_d;
   logic [2:0]       op_q, op_d, opd_q, opd_d;
   logic             err_q, err_d;
   logic [2:0]       mem_q [PROG_DEPTH];
   logic [2:0]       fifo_q [OUT_DEPTH];
   logic [FW-1:0]    wr_q, rd_q;
   logic [FW:0]      cnt_q;

   logic [REG_W-1:0] combo, shifted;
   logic             combo_bad, uses_combo, fifo_full, push, pop;
   logic [IPW-1:0]   ip_p1;

   // Words past the memory end read as zero (prog_len can exceed PROG_DEPTH).
   function automatic logic [2:0] rd_word(input logic [IPW-1:0] idx);
      if (idx < IPW'(PROG_DEPTH)) return mem_q[idx[PW-1:0]];
      return 3'd0;
   endfunction

   assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_STALL);
   assign halt      = (state_q == S_DONE);
   assign error     = err_q;
   assign dbg_a     = a_q;
   assign dbg_b     = b_q;
   assign dbg_c     = c_q;
   assign fifo_full = (cnt_q == (FW+1)'(OUT_DEPTH));
   assign pop       = out_if.out_valid && out_if.out_ready;
   assign ip_p1     = ip_q + 1'b1;

   assign out_if.out_valid = (cnt_q != '0);
   assign out_if.out_data  = out_if.out_valid ? fifo_q[rd_q] : 3'd0;

   // Combo operand decode and the shared A >> combo divider; the full-width compare avoids truncated shift amounts.
   always_comb begin
      combo     = '0;
      combo_bad = 1'b0;
      case (opd_q)
         3'd4:    combo = a_q;
         3'd5:    combo = b_q;
         3'd6:    combo = c_q;
         3'd7:    combo_bad = 1'b1;
         default: combo = REG_W'(opd_q);
      endcase
      shifted    = (combo >= REG_W'(REG_W)) ? '0 : (a_q >> combo);
      uses_combo = (op_q != 3'd1) && (op_q != 3'd3) && (op_q != 3'd4);
   end

   // Next-state logic for the FSM, registers and instruction pointer.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      ip_d    = ip_q;
      len_d   = len_q;
      op_d    = op_q;
      opd_d   = opd_q;
      err_d   = err_q;
      push    = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               a_d     = init_a;
               b_d     = init_b;
               c_d     = init_c;
               ip_d    = '0;
               len_d   = prog_len;
               err_d   = 1'b0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (ip_p1 >= IPW'(len_q)) begin
               state_d = S_DONE;
            end else begin
               op_d    = rd_word(ip_q);
               opd_d   = rd_word(ip_p1);
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            ip_d    = ip_q + IPW'(2);
            state_d = S_FETCH;
            if (uses_combo && combo_bad) begin
               ip_d    = ip_q;
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               case (op_q)
                  3'd0: a_d = shifted;
                  3'd1: b_d = b_q ^ REG_W'(opd_q);
                  3'd2: b_d = REG_W'(combo[2:0]);
                  3'd3: if (a_q != '0) ip_d = IPW'(opd_q);
                  3'd4: b_d = b_q ^ c_q;
                  3'd5: begin
                     if (fifo_full) begin
                        ip_d    = ip_q;
                        state_d = S_STALL;
                     end else begin
                        push = 1'b1;
                     end
                  end
                  3'd6: b_d = shifted;
                  3'd7: c_d = shifted;
                  default: ;
               endcase
            end
         end
         S_STALL: begin
            // Uses the registered count, so a same-cycle pop releases the stall one cycle later.
            if (!fifo_full) begin
               push    = 1'b1;
               ip_d    = ip_q + IPW'(2);
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Core state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         ip_q    <= '0;
         len_q   <= '0;
         op_q    <= '0;
         opd_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         ip_q    <= ip_d;
         len_q   <= len_d;
         op_q    <= op_d;
         opd_q   <= opd_d;
         err_q   <= err_d;
      end
   end

   // Program memory; writes are locked out while running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PROG_DEPTH; i++) mem_q[i] <= '0;
      end else if (load_en && !busy && ({1'b0, load_addr} < (PW+1)'(PROG_DEPTH))) begin
         mem_q[load_addr] <= load_data;
      end
   end

   // Output FIFO; pointers wrap naturally because OUT_DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < OUT_DEPTH; i++) fifo_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_q] <= combo[2:0];
            wr_q         <= wr_q + 1'b1;
         end
         if (pop) rd_q <= rd_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: tb/tb_chronospatial_cpu.sv
// Bench for chronospatial_cpu: directed programs with a scoreboard on the output stream.
// Expected outputs are queued at stimulus time and popped by an independent monitor.
// Register, flag and latency checks run inline in the stimulus process.
module tb_chronospatial_cpu;
   localparam int REG_W = 48;
   localparam int PROG_DEPTH = 16;
   localparam int OUT_DEPTH = 4;
   localparam int PW = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             load_en, start;
   logic [PW-1:0]    load_addr;
   logic [2:0]       load_data;
   logic [PW:0]      prog_len;
   logic [REG_W-1:0] init_a, init_b, init_c;
   logic             busy, halt, error;
   logic [REG_W-1:0] dbg_a, dbg_b, dbg_c;

   chronospatial_cpu_if oif ();

   chronospatial_cpu #(.REG_W(REG_W), .PROG_DEPTH(PROG_DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .prog_len(prog_len), .init_a(init_a), .init_b(init_b),
      .init_c(init_c), .start(start), .busy(busy), .halt(halt), .error(error),
      .dbg_a(dbg_a), .dbg_b(dbg_b), .dbg_c(dbg_c), .out_if(oif)
   );

   always #5 clk = ~clk;

   int         errors = 0;
   int         checks = 0;
   logic [2:0] exp_q[$];
   logic [2:0] mon_exp;
   int         cyc;

   typedef logic [2:0] prog_t [8];
   localparam prog_t P729 = '{3'd0, 3'd1, 3'd5, 3'd4, 3'd3, 3'd0, 3'd0, 3'd0};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_prog(input prog_t w, input int n);
      for (int i = 0; i < n; i++) begin
         load_en = 1'b1; load_addr = PW'(i); load_data = w[i];
         tick(1);
      end
      load_en = 1'b0;
   endtask

   task automatic start_run(input logic [REG_W-1:0] a, b, c, input int len);
      init_a = a; init_b = b; init_c = c; prog_len = (PW+1)'(len);
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_halt(input int maxc, output int n);
      n = 0;
      while (!halt && n < maxc) begin
         tick(1);
         n++;
      end
      checks++;
      if (!halt) begin
         errors++;
         $display("FAIL halt_timeout: got halt=0 after %0d cycles expected halt=1", n);
      end
   endtask

   task automatic push_729();
      exp_q.push_back(3'd4); exp_q.push_back(3'd6); exp_q.push_back(3'd3);
      exp_q.push_back(3'd5); exp_q.push_back(3'd6); exp_q.push_back(3'd3);
      exp_q.push_back(3'd5); exp_q.push_back(3'd2); exp_q.push_back(3'd1);
      exp_q.push_back(3'd0);
   endtask

   // Monitor: every accepted output beat is compared against the scoreboard head.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && oif.out_valid && oif.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL out_unexpected: got %0d expected no output", oif.out_data);
            end else begin
               mon_exp = exp_q.pop_front();
               if (oif.out_data !== mon_exp) begin
                  errors++;
                  $display("FAIL out_data: got %0d expected %0d", oif.out_data, mon_exp);
               end
            end
         end
      end
   end

   initial begin
      load_en = 0; load_addr = 0; load_data = 0; start = 0; prog_len = 0;
      init_a = 0; init_b = 0; init_c = 0; oif.out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", busy, 0);         chk("rst_halt", halt, 0);
      chk("rst_error", error, 0);       chk("rst_out_valid", oif.out_valid, 0);
      chk("rst_out_data", oif.out_data, 0);
      chk("rst_a", dbg_a, 0); chk("rst_b", dbg_b, 0); chk("rst_c", dbg_c, 0);
      oif.out_ready = 1'b1;
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      tick(1);

      // 729 reference program, free-flowing output
      load_prog(P729, 6);
      push_729();
      start_run(729, 0, 0, 6);
      wait_halt(2000, cyc);
      chk("729_error", error, 0);
      tick(6);
      chk("729_drained", exp_q.size(), 0);

      // Same program with the sink blocked: FIFO fills and the CPU stalls
      oif.out_ready = 1'b0;
      push_729();
      start_run(729, 0, 0, 6);
      tick(60);
      chk("stall_busy", busy, 1); chk("stall_halt", halt, 0);
      chk("stall_valid", oif.out_valid, 1); chk("stall_head", oif.out_data, 4);
      oif.out_ready = 1'b1;
      wait_halt(2000, cyc);
      tick(6);
      chk("stall_drained", exp_q.size(), 0);

      // bst of C, latency of a one-instruction program
      load_prog('{3'd2, 3'd6, 0, 0, 0, 0, 0, 0}, 2);
      start_run(0, 0, 9, 2);
      wait_halt(100, cyc);
      chk("bst_latency", cyc + 1, 4);
      chk("bst_b", dbg_b, 1);
      // bxl with literal 7 is legal
      load_prog('{3'd1, 3'd7, 0, 0, 0, 0, 0, 0}, 2);
      start_run(0, 29, 0, 2);
      wait_halt(100, cyc);
      chk("bxl_b", dbg_b, 26); chk("bxl_error", error, 0);

      // adv by B: untruncated >= width, exactly width, and normal shift
      load_prog('{3'd0, 3'd5, 0, 0, 0, 0, 0, 0}, 2);
      start_run(5, 64, 0, 2);  wait_halt(100, cyc); chk("adv_b64", dbg_a, 0);
      start_run(5, 48, 0, 2);  wait_halt(100, cyc); chk("adv_b48", dbg_a, 0);
      start_run(100, 2, 0, 2); wait_halt(100, cyc); chk("adv_b2", dbg_a, 25);
      load_prog('{3'd0, 3'd4, 0, 0, 0, 0, 0, 0}, 2);
      start_run(47, 0, 0, 2);  wait_halt(100, cyc); chk("adv_self", dbg_a, 0);

      // bdv then cdv
      load_prog('{3'd6, 3'd2, 3'd7, 3'd3, 0, 0, 0, 0}, 4);
      start_run(64, 0, 0, 4);
      wait_halt(100, cyc);
      chk("bdv_b", dbg_b, 16); chk("cdv_c", dbg_c, 8); chk("bdv_a", dbg_a, 64);

      // jnz to an odd target, then the not-taken path with two outs
      load_prog('{3'd3, 3'd3, 3'd5, 3'd1, 3'd5, 3'd4, 3'd0, 0}, 7);
      start_run(1, 0, 8, 7);
      wait_halt(200, cyc);
      chk("jnz_odd_b", dbg_b, 13);
      exp_q.push_back(3'd1); exp_q.push_back(3'd0);
      start_run(0, 0, 8, 7);
      wait_halt(200, cyc);
      chk("jnz_nt_b", dbg_b, 0);
      tick(4);
      chk("jnz_drained", exp_q.size(), 0);

      // Illegal combo operand, then a restart clears the flag
      load_prog('{3'd5, 3'd7, 0, 0, 0, 0, 0, 0}, 2);
      start_run(0, 0, 0, 2);
      wait_halt(100, cyc);
      chk("err_flag", error, 1); chk("err_halt", halt, 1); chk("err_fifo", oif.out_valid, 0);
      start_run(0, 0, 0, 0);
      wait_halt(100, cyc);
      chk("len0_latency", cyc, 1);
      chk("err_cleared", error, 0);

      // Load and start in the same cycle: the new word is fetched
      load_prog('{3'd1, 3'd0, 0, 0, 0, 0, 0, 0}, 2);
      load_en = 1'b1; load_addr = 1; load_data = 3'd6;
      init_a = 0; init_b = 0; init_c = 0; prog_len = 2; start = 1'b1;
      tick(1);
      load_en = 1'b0; start = 1'b0;
      wait_halt(100, cyc);
      chk("load_start_b", dbg_b, 6);

      // load_en and start while busy are ignored
      load_prog(P729, 6);
      push_729();
      start_run(729, 0, 0, 6);
      tick(3);
      load_en = 1'b1; load_addr = 3; load_data = 3'd7;
      init_a = 8; start = 1'b1;
      tick(1);
      load_en = 1'b0; start = 1'b0;
      wait_halt(2000, cyc);
      chk("busy_ign_error", error, 0);
      tick(6);
      chk("busy_ign_drained", exp_q.size(), 0);

      // Reset during EXEC of the third out, with entries queued
      oif.out_ready = 1'b0;
      start_run(729, 0, 0, 6);
      tick(15);
      chk("pre_rst_valid", oif.out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0); chk("mid_rst_halt", halt, 0);
      chk("mid_rst_valid", oif.out_valid, 0); chk("mid_rst_data", oif.out_data, 0);
      chk("mid_rst_a", dbg_a, 0);
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      oif.out_ready = 1'b1;
      tick(20);
      chk("post_rst_valid", oif.out_valid, 0); chk("post_rst_busy", busy, 0);
      start_run(8, 0, 0, 2);
      wait_halt(100, cyc);
      chk("post_rst_mem_zero", dbg_a, 8);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
